// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants and receiver state encoding
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flop chain that brings an asynchronous bit into the clk domain
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] chain;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chain <= {DEPTH{RST_VAL}};
    else chain <= {chain[DEPTH-2:0], d};
  assign q = chain[DEPTH-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver sampling each bit at its midpoint, with valid and framing-error strobes
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      busy
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [UART_DATA_BITS-1:0] sh, sh_n, data_n;
  logic valid_n, ferr_n, rx_s, bit_end, half_end;
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s)
  );
  assign bit_end  = cnt == CW'(CLKS_PER_BIT - 1);
  assign half_end = cnt == CW'(H - 1);
  assign busy     = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = data_out;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: if (half_end) begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_n = '0;
        sh_n  = {rx_s, sh[UART_DATA_BITS-1:1]};
        idx_n = idx + 1'b1;
        if (idx == IW'(UART_DATA_BITS - 1)) state_n = STOP;
      end
      STOP: if (bit_end) begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : BREAK;
        valid_n = rx_s;
        ferr_n  = !rx_s;
        data_n  = rx_s ? sh : data_out;
      end
      // a held-low line must go high before another start can be recognised
      BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      data_out  <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized frame checks against an event-level receiver model
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int LAT = 154;
  typedef struct {int kind; logic [7:0] data; int cyc;} ev_t;
  typedef struct {logic [7:0] d; logic stop; int hold_low; int exp_kind; logic [7:0] exp_data;} vec_t;
  logic clk = 1'b0, rst_n, rx = 1'b1;
  logic [7:0] data_out;
  logic valid, frame_err, busy;
  int cyc = 0, checks = 0, errors = 0;
  ev_t got_q[$], exp_q[$];
  logic busy_log[int];
  vec_t vecs[4];
  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out),
    .valid(valid), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n) begin
    busy_log[cyc] = busy;
    if (valid) got_q.push_back('{1, data_out, cyc});
    if (frame_err) got_q.push_back('{2, data_out, cyc});
    if (valid && frame_err) begin
      checks++;
      errors++;
      $display("FAIL exclusive: valid and frame_err both 1 at cycle %0d", cyc);
    end
  end
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask
  // start bit goes low just after an edge, so the next edge is T0
  task automatic send_frame(input logic [7:0] d, input logic stop, input int kind,
                            input logic [7:0] exp_data, output int t0);
    t0 = cyc + 1;
    exp_q.push_back('{kind, exp_data, t0 + LAT});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask
  task automatic compare_events(input string tag);
    repeat (40) @(posedge clk);
    #1;
    chk({tag, " event count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s ev%0d kind", tag, i), got_q[i].kind, exp_q[i].kind);
      chk($sformatf("%s ev%0d data", tag, i), int'(got_q[i].data), int'(exp_q[i].data));
      chk($sformatf("%s ev%0d cycle", tag, i), got_q[i].cyc, exp_q[i].cyc);
    end
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int t0;
    logic [7:0] last_good, d;
    logic stop;
    vecs[0] = '{8'h41, 1'b1, 0, 1, 8'h41};
    vecs[1] = '{8'h42, 1'b1, 0, 1, 8'h42};
    vecs[2] = '{8'h55, 1'b0, 40, 2, 8'h42};
    vecs[3] = '{8'hA5, 1'b1, 0, 1, 8'hA5};
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk("reset data_out", int'(data_out), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset busy", int'(busy), 0);
    rx = 1'b1;
    #2 rst_n = 1'b1;
    idle(20);
    chk("post-reset busy", int'(busy), 0);
    compare_events("post-reset");
    send_frame(8'h41, 1'b1, 1, 8'h41, t0);
    idle(10);
    compare_events("single");
    chk("busy before T0+2", int'(busy_log[t0 + 1]), 0);
    chk("busy at T0+2", int'(busy_log[t0 + 2]), 1);
    chk("busy at T0+153", int'(busy_log[t0 + 153]), 1);
    chk("busy after T0+154", int'(busy_log[t0 + 154]), 0);
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].exp_kind, vecs[i].exp_data, t0);
      if (vecs[i].hold_low > 0) begin
        repeat (vecs[i].hold_low) @(posedge clk);
        #1;
        idle(20);
      end
    end
    idle(20);
    compare_events("table");
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    compare_events("glitch");
    chk("glitch data_out", int'(data_out), 8'hA5);
    chk("glitch busy", int'(busy), 0);
    drive_bit(1'b0);
    d = 8'h3C;
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset data_out", int'(data_out), 0);
    chk("midreset busy", int'(busy), 0);
    chk("midreset valid", int'(valid), 0);
    chk("midreset frame_err", int'(frame_err), 0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(30);
    compare_events("midreset");
    send_frame(8'hC3, 1'b1, 1, 8'hC3, t0);
    idle(10);
    compare_events("after midreset");
    last_good = 8'hC3;
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      stop = ($urandom_range(5) != 0);
      if ($urandom_range(7) == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(6, 1)) @(posedge clk);
        #1;
        idle(20 + $urandom_range(10));
      end
      send_frame(d, stop, stop ? 1 : 2, stop ? d : last_good, t0);
      if (stop) begin
        last_good = d;
        idle($urandom_range(20));
      end else begin
        repeat ($urandom_range(40)) @(posedge clk);
        #1;
        idle(20 + $urandom_range(10));
      end
    end
    compare_events("random");
    chk("final data_out", int'(data_out), int'(last_good));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that consumes the serial line driven by the team's uart_tx. Frame format matches: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1), no parity.
- Synchronises the asynchronous rx input and samples each bit at its midpoint using a per-bit clock counter.
- Delivers each received byte on data_out with a one-cycle valid strobe. Flags framing errors.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4
- SYNC_STAGES, 2, flip-flops in the rx input synchroniser; must be >= 2

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk
- rx  input  1  serial line, idles high, asynchronous to clk
- data_out  output  8  last correctly received byte; held until the next good frame
- valid  output  1  one-cycle pulse when data_out is updated
- frame_err  output  1  one-cycle pulse when the stop bit samples 0
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - data_out=8'h00, valid=0, frame_err=0, busy=0.
  - Synchroniser flops preset to 1 (line idle). State=IDLE, counter=0, bit index=0.
- Reset asserted mid-frame aborts immediately. No valid or frame_err pulse is produced for the aborted frame.
- rx_s is the output of the SYNC_STAGES flop chain. All FSM decisions use rx_s only.
- H = CLKS_PER_BIT/2. The counter is clog2(CLKS_PER_BIT) bits wide. The counter is cleared on every state transition.
- IDLE:
  - rx_s==0 -> START.
- START:
  - Counter increments each cycle.
  - At counter==H-1: if rx_s==0 -> DATA (midpoint of start bit); else -> IDLE (glitch rejection, no outputs).
- DATA:
  - Counter increments each cycle.
  - At counter==CLKS_PER_BIT-1: shift rx_s into shift-register MSB (right shift, so the first bit ends in bit 0); bit index++ and counter cleared.
  - After the 8th sample -> STOP.
- STOP, at counter==CLKS_PER_BIT-1:
  - rx_s==1: data_out<=shift register, valid<=1 for one cycle -> IDLE.
  - rx_s==0: frame_err<=1 for one cycle, data_out unchanged -> BREAK.
- BREAK:
  - Wait until rx_s==1 -> IDLE. This prevents a held-low line (break) from retriggering START.
- Return to IDLE happens at mid-stop-bit. A back-to-back next start bit is therefore detected with up to H cycles of margin.
- Latency: let T0 be the first clk edge at which rx=0 is captured by sync stage 1. valid rises after edge T0 + (SYNC_STAGES-1) + 1 + H + 9*CLKS_PER_BIT. With defaults this is T0+154.
- valid and frame_err are mutually exclusive and never high in consecutive cycles for the same frame.
- The upstream consumer must accept data_out within one frame time. There is no buffering or overrun detection.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - UART_DATA_BITS=8
  - the default CLKS_PER_BIT
- uart_tx is to be updated to import uart_pkg for the same constants.
- One sub-module: sync_ff (parameterised depth and reset value) for the rx synchroniser.
- The FSM and counter remain in uart_rx.

Test Plan:
- Reset: hold rst_n=0 with rx toggling -> data_out=8'h00, valid=0, frame_err=0, busy=0. Release rst_n -> still idle, no pulses.
- Single frame: drive 0x41 at CLKS_PER_BIT=16 -> valid pulses exactly once at T0+154, data_out=8'h41, busy high from T0+2 to T0+154.
- Loopback with uart_tx: send 0x41 then 0x42 back-to-back via uart_tx -> two valid pulses, data_out 8'h41 then 8'h42, frame_err never asserted.
- Glitch: rx low for 4 cycles, then high -> FSM returns to IDLE, no valid, no frame_err, data_out unchanged.
- Framing error: send 0x55 with stop bit forced 0, held low 40 cycles, then high -> frame_err single pulse, data_out keeps previous value. Then send 0xA5 -> valid, data_out=8'hA5.
- Mid-frame reset: assert rst_n=0 during data bit 4 of 0x3C -> outputs return to reset values, no pulse. A following frame 0xC3 is received correctly.
